// File: rtl/comparator_driver_if.sv
// Purpose: bundles the control, operand, flag and result signals between the sweep driver and its environment.
// Latency: n/a (wires only).
// Backpressure: none; start/abort are single-cycle requests and the flags are sampled, not handshaken.
// Ports: master = driver side (drives A/B and results, receives start/abort/flags);
//        slave  = stimulus/comparator side (the mirror image).
interface comparator_driver_if;
   logic       start;
   logic       abort;
   logic [3:0] A;
   logic [3:0] B;
   logic       greater;
   logic       lesser;
   logic       equal;
   logic       busy;
   logic       done;
   logic       pass;
   logic [8:0] err_count;
   logic       fail_valid;
   logic [3:0] fail_a;
   logic [3:0] fail_b;
   logic [2:0] fail_flags;

   modport master (
      input  start, abort, greater, lesser, equal,
      output A, B, busy, done, pass, err_count, fail_valid, fail_a, fail_b, fail_flags
   );

   modport slave (
      output start, abort, greater, lesser, equal,
      input  A, B, busy, done, pass, err_count, fail_valid, fail_a, fail_b, fail_flags
   );
endinterface

// File: rtl/comparator_driver.sv
// Purpose: exhaustive 4-bit comparator tester; sweeps all 256 A/B pairs and records mismatches.
// Latency: SETTLE+1 cycles per vector, 256*(SETTLE+1) cycles per sweep, then a one-cycle done pulse.
// Backpressure: none; start is ignored while busy, abort ends a sweep without a done pulse.
// Ports: clk, rst_n (synchronous, active-low); bus (master modport) carries start/abort in,
//        A/B out to the comparator, greater/lesser/equal back, and busy/done/pass/err_count/fail_* results.
module comparator_driver #(
   parameter int unsigned SETTLE = 1   // cycles A/B are held before sampling, 1..15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   comparator_driver_if.master        bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // settle counter runs 0..SETTLE-1 while in DRIVE
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_nxt;

   logic [7:0] idx;
   logic [7:0] idx_inc;
   logic [3:0] settle_cnt;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       pass_q;
   logic [8:0] err_q;
   logic [8:0] err_nxt;
   logic       fail_valid_q;
   logic [3:0] fail_a_q;
   logic [3:0] fail_b_q;
   logic [2:0] fail_flags_q;

   logic [2:0] obs_flags;
   logic [2:0] ref_flags;
   logic       mismatch;
   logic       busy;
   logic       done;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   // abort only matters in DRIVE/SAMPLE; in IDLE start always wins.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.start) state_nxt = DRIVE;
         end
         DRIVE: begin
            if (bus.abort)                      state_nxt = IDLE;
            else if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (bus.abort)          state_nxt = IDLE;
            else if (idx == 8'hFF)  state_nxt = DONE;
            else                    state_nxt = DRIVE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         DRIVE, SAMPLE: busy = 1'b1;
         DONE:          done = 1'b1;
         default:       ;
      endcase
   end

   // ---------------- compare path ----------------
   // Any bit difference counts once, so "no flag" and "several flags" both mismatch.
   assign obs_flags = {bus.greater, bus.lesser, bus.equal};
   assign ref_flags = {a_q > b_q, a_q < b_q, a_q == b_q};
   assign mismatch  = (obs_flags != ref_flags);
   assign idx_inc   = idx + 8'd1;

   // Saturate rather than wrap; 256 is the real maximum so this never engages in practice.
   assign err_nxt   = (mismatch && (err_q != 9'h1FF)) ? err_q + 9'd1 : err_q;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx          <= 8'd0;
         settle_cnt   <= 4'd0;
         a_q          <= 4'd0;
         b_q          <= 4'd0;
         pass_q       <= 1'b0;
         err_q        <= 9'd0;
         fail_valid_q <= 1'b0;
         fail_a_q     <= 4'd0;
         fail_b_q     <= 4'd0;
         fail_flags_q <= 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  // vector 0 is A=0,B=0, so the operand registers simply clear
                  idx          <= 8'd0;
                  settle_cnt   <= 4'd0;
                  a_q          <= 4'd0;
                  b_q          <= 4'd0;
                  pass_q       <= 1'b0;
                  err_q        <= 9'd0;
                  fail_valid_q <= 1'b0;
                  fail_a_q     <= 4'd0;
                  fail_b_q     <= 4'd0;
                  fail_flags_q <= 3'd0;
               end
            end
            DRIVE: begin
               if (bus.abort) begin
                  a_q        <= 4'd0;
                  b_q        <= 4'd0;
                  settle_cnt <= 4'd0;
                  pass_q     <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            SAMPLE: begin
               if (bus.abort) begin
                  a_q    <= 4'd0;
                  b_q    <= 4'd0;
                  pass_q <= 1'b0;
               end else begin
                  err_q <= err_nxt;
                  if (mismatch && !fail_valid_q) begin
                     fail_valid_q <= 1'b1;
                     fail_a_q     <= a_q;
                     fail_b_q     <= b_q;
                     fail_flags_q <= obs_flags;
                  end
                  settle_cnt <= 4'd0;
                  if (idx == 8'hFF) begin
                     a_q    <= 4'd0;
                     b_q    <= 4'd0;
                     // err_nxt includes the final vector's result
                     pass_q <= (err_nxt == 9'd0);
                  end else begin
                     idx <= idx_inc;
                     a_q <= idx_inc[7:4];
                     b_q <= idx_inc[3:0];
                  end
               end
            end
            default: begin
               // DONE: results hold; operands already cleared on entry
            end
         endcase
      end
   end

   // ---------------- output mapping ----------------
   assign bus.A          = a_q;
   assign bus.B          = b_q;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.fail_valid = fail_valid_q;
   assign bus.fail_a     = fail_a_q;
   assign bus.fail_b     = fail_b_q;
   assign bus.fail_flags = fail_flags_q;

endmodule

// File: doc/comparator_driver.md
COMPARATOR_DRIVER -- requirements
Module: comparator_driver

Interface
REQ-001 SHALL have parameter SETTLE, default 1: cycles A/B are held before flags are sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 SHALL have port abort  input  1  terminates a sweep in progress.
REQ-006 SHALL have port A  output  4  operand A driven to the comparator under test.
REQ-007 SHALL have port B  output  4  operand B driven to the comparator under test.
REQ-008 SHALL have port greater  input  1  comparator flag, expected 1 iff A>B.
REQ-009 SHALL have port lesser  input  1  comparator flag, expected 1 iff A<B.
REQ-010 SHALL have port equal  input  1  comparator flag, expected 1 iff A==B.
REQ-011 SHALL have port busy  output  1  high while a sweep is active.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-013 SHALL have port pass  output  1  high after a completed sweep with zero mismatches.
REQ-014 SHALL have port err_count  output  9  mismatch count of the current/last sweep (0..256).
REQ-015 SHALL have port fail_valid  output  1  first-failure record valid.
REQ-016 SHALL have port fail_a, fail_b  output  4 each  operands of first failing vector.
REQ-017 SHALL have port fail_flags  output  3  {greater,lesser,equal} observed at first failure.

Function
REQ-018 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-019 IDLE: A=B=0, busy=0; start=1 -> clear err_count, fail_valid, pass, fail_* ; vector index idx=0; go DRIVE.
REQ-020 Vector order SHALL be idx 0..255 with A=idx[7:4], B=idx[3:0].
REQ-021 DRIVE: A,B registered from idx on DRIVE entry and held stable; after SETTLE cycles in DRIVE go SAMPLE.
REQ-022 SAMPLE: observed flags SHALL be compared against {A>B, A<B, A==B} computed internally as unsigned 4-bit; any bit difference (including zero or multiple flags high) is one mismatch.
REQ-023 On mismatch err_count SHALL increment by 1; if fail_valid=0, capture fail_a=A, fail_b=B, fail_flags=observed, set fail_valid=1; later mismatches SHALL NOT overwrite the record.
REQ-024 SAMPLE with idx<255 -> idx+1, DRIVE; idx==255 -> DONE.
REQ-025 Each vector SHALL take exactly SETTLE+1 cycles; a full sweep 256*(SETTLE+1) cycles from first DRIVE cycle to DONE entry.
REQ-026 DONE: done=1 for exactly one cycle, pass=(err_count==0) registered, busy=0, A=B=0; next state IDLE.
REQ-027 busy SHALL be 1 in DRIVE and SAMPLE only.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in DRIVE or SAMPLE -> IDLE next cycle, done not pulsed, pass=0, err_count and fail_* retain values; abort in IDLE/DONE ignored.
REQ-030 abort and start simultaneously in IDLE: start SHALL win (abort ignored in IDLE).
REQ-031 err_count SHALL NOT wrap (max reachable 256 fits 9 bits).
REQ-032 pass, err_count, fail_* SHALL hold until next start or reset.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, idx=0, A=B=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_a=fail_b=0, fail_flags=0.
REQ-034 Reset mid-sweep SHALL take priority over abort/start and abandon the sweep with no done pulse.

Verification
REQ-035 Reset: drive rst_n=0 two cycles mid-sweep -> next cycle all outputs zero, state IDLE.
REQ-036 Golden comparator, SETTLE=1, start pulse -> busy 512 cycles, done pulse one cycle later, err_count=0, pass=1, fail_valid=0.
REQ-037 Model with equal stuck at 0 -> err_count=16, fail_valid=1, fail_a=0, fail_b=0, fail_flags=3'b000, pass=0.
REQ-038 Model with greater/lesser swapped -> err_count=240, fail_a=0, fail_b=1, fail_flags=3'b100.
REQ-039 SETTLE=3, abort asserted while A=4'b0110,B=4'b0100 -> busy=0 next cycle, done never pulses, A=B=0, err_count retained.
REQ-040 start re-pulsed at vector 50 -> ignored, sweep completes at original cycle count; second start after done -> counters cleared, sweep restarts at A=0,B=0.
